ula_74181: RTL and testbench

//  4-bit ALU modelled on the 74181 function set: 16 logic functions (m=1) and
//  16 arithmetic functions (m=0) chosen by s, with carry-in/out, group

---
 rtl/ula_74181_pkg.sv | 43 ++++
 rtl/ula_74181_core.sv | 109 ++++++++++
 rtl/ula_74181.sv | 47 ++++
 tb/tb_ula_74181.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ula_74181_pkg.sv
// Shared definitions for the 74181-style ALU: function-select codes,
// the result bundle passed from the combinational core to the output
// register, and a helper that identifies the borrow-sense selections.
package ula_74181_pkg;

    // Function-select codes. Comments give the logic-mode (m=1) result
    // first and the arithmetic-mode (m=0) sum second.
    localparam logic [3:0] SEL_0 = 4'h0;  // ~a            | a + 1111
    localparam logic [3:0] SEL_1 = 4'h1;  // ~(a|b)        | a + (a|b)
    localparam logic [3:0] SEL_2 = 4'h2;  // ~a&b          | (a|b) + 1111
    localparam logic [3:0] SEL_3 = 4'h3;  // 0000          | 0 + 1111
    localparam logic [3:0] SEL_4 = 4'h4;  // ~(a&b)        | a + (a&b)
    localparam logic [3:0] SEL_5 = 4'h5;  // ~b            | (a|b) + (a&b)
    localparam logic [3:0] SEL_6 = 4'h6;  // a^b           | a + ~b
    localparam logic [3:0] SEL_7 = 4'h7;  // a&~b          | (a&~b) + 1111
    localparam logic [3:0] SEL_8 = 4'h8;  // a&b           | a + (a&~b)
    localparam logic [3:0] SEL_9 = 4'h9;  // ~(a^b)        | a + b
    localparam logic [3:0] SEL_A = 4'hA;  // b             | (a|~b) + (a&b)
    localparam logic [3:0] SEL_B = 4'hB;  // ~a|b          | (a&b) + 1111
    localparam logic [3:0] SEL_C = 4'hC;  // 1111          | a + a
    localparam logic [3:0] SEL_D = 4'hD;  // a|~b          | (a|b) + a
    localparam logic [3:0] SEL_E = 4'hE;  // a|b           | (a|~b) + a
    localparam logic [3:0] SEL_F = 4'hF;  // a             | a + 0000

    // Everything the ALU reports for one operation.
    typedef struct packed {
        logic [3:0] f;
        logic       c_out;
        logic       p;
        logic       g;
        logic       a_eq_b;
    } result_t;

    // Selections whose addend is all-ones (or ~b) behave as subtractions,
    // so their carry-out is reported inverted as a borrow indication.
    function automatic logic isBorrowSense(input logic [3:0] sel);
        case (sel)
            SEL_0, SEL_2, SEL_3, SEL_6, SEL_7, SEL_B: isBorrowSense = 1'b1;
            default:                                  isBorrowSense = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ula_74181_core.sv
// Purely combinational 74181-style function block. Produces the result,
// carry-out, group propagate/generate and operand-equality flag for one
// set of operands; the top level registers whatever this produces.
module ula_74181_core
    import ula_74181_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_c_in,
    output result_t    o_res
);

    logic [3:0] w_logicF;
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [3:0] w_q;
    logic [4:0] w_sum;
    logic [3:0] w_pb;
    logic [3:0] w_gb;
    logic       w_groupP;
    logic       w_groupG;

    // Logic-mode result: one bitwise function of a and b per select code.
    always_comb begin
        w_logicF = 4'b0000;
        case (i_s)
            SEL_0: w_logicF = ~i_a;
            SEL_1: w_logicF = ~(i_a | i_b);
            SEL_2: w_logicF = ~i_a & i_b;
            SEL_3: w_logicF = 4'b0000;
            SEL_4: w_logicF = ~(i_a & i_b);
            SEL_5: w_logicF = ~i_b;
            SEL_6: w_logicF = i_a ^ i_b;
            SEL_7: w_logicF = i_a & ~i_b;
            SEL_8: w_logicF = i_a & i_b;
            SEL_9: w_logicF = ~(i_a ^ i_b);
            SEL_A: w_logicF = i_b;
            SEL_B: w_logicF = ~i_a | i_b;
            SEL_C: w_logicF = 4'b1111;
            SEL_D: w_logicF = i_a | ~i_b;
            SEL_E: w_logicF = i_a | i_b;
            SEL_F: w_logicF = i_a;
            default: w_logicF = 4'b0000;
        endcase
    end

    // Arithmetic-mode operands X, Y and the look-ahead term Q. Q is chosen
    // separately from Y because the two differ for several select codes
    // and propagate/generate must follow Q.
    always_comb begin
        w_x = i_a;
        w_y = 4'b0000;
        w_q = 4'b0000;
        case (i_s)
            SEL_0: begin w_x = i_a;         w_y = 4'b1111;     w_q = 4'b1111;     end
            SEL_1: begin w_x = i_a;         w_y = i_a | i_b;   w_q = i_a | i_b;   end
            SEL_2: begin w_x = i_a | i_b;   w_y = 4'b1111;     w_q = i_a | i_b;   end
            SEL_3: begin w_x = 4'b0000;     w_y = 4'b1111;     w_q = 4'b1111;     end
            SEL_4: begin w_x = i_a;         w_y = i_a & i_b;   w_q = i_a & i_b;   end
            SEL_5: begin w_x = i_a | i_b;   w_y = i_a & i_b;   w_q = i_a | i_b;   end
            SEL_6: begin w_x = i_a;         w_y = ~i_b;        w_q = ~i_b;        end
            SEL_7: begin w_x = i_a & ~i_b;  w_y = 4'b1111;     w_q = i_a & ~i_b;  end
            SEL_8: begin w_x = i_a;         w_y = i_a & ~i_b;  w_q = i_a & ~i_b;  end
            SEL_9: begin w_x = i_a;         w_y = i_b;         w_q = i_b;         end
            SEL_A: begin w_x = i_a | ~i_b;  w_y = i_a & i_b;   w_q = i_a | ~i_b;  end
            SEL_B: begin w_x = i_a & i_b;   w_y = 4'b1111;     w_q = i_a & i_b;   end
            SEL_C: begin w_x = i_a;         w_y = i_a;         w_q = i_a;         end
            SEL_D: begin w_x = i_a | i_b;   w_y = i_a;         w_q = i_a | i_b;   end
            SEL_E: begin w_x = i_a | ~i_b;  w_y = i_a;         w_q = i_a | ~i_b;  end
            SEL_F: begin w_x = i_a;         w_y = 4'b0000;     w_q = i_a;         end
            default: begin w_x = i_a;       w_y = 4'b0000;     w_q = i_a;         end
        endcase
    end

    // Five-bit sum so the carry out of bit 3 is kept; the result wraps mod 16.
    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, i_c_in};

    // Bit-level propagate/generate from a and Q, then the 4-bit group
    // look-ahead terms. Carry-in deliberately plays no part here.
    assign w_pb     = i_a | w_q;
    assign w_gb     = i_a & w_q;
    assign w_groupP = &w_pb;
    assign w_groupG = w_gb[3]
                    | (w_pb[3] & w_gb[2])
                    | (w_pb[3] & w_pb[2] & w_gb[1])
                    | (w_pb[3] & w_pb[2] & w_pb[1] & w_gb[0]);

    // Mode mux: logic mode pins carry/propagate/generate to fixed values,
    // arithmetic mode reports the sum and look-ahead terms. The equality
    // flag compares the raw operands regardless of mode.
    always_comb begin
        o_res        = '0;
        o_res.a_eq_b = (i_a == i_b);
        if (i_m) begin
            o_res.f     = w_logicF;
            o_res.c_out = 1'b0;
            o_res.p     = 1'b0;
            o_res.g     = 1'b1;
        end else begin
            o_res.f     = w_sum[3:0];
            o_res.c_out = isBorrowSense(i_s) ? ~w_sum[4] : w_sum[4];
            o_res.p     = w_groupP;
            o_res.g     = w_groupG;
        end
    end

endmodule

// File: rtl/ula_74181.sv
// 4-bit 74181-style ALU with a registered output stage. The combinational
// core is sampled on every rising clock, giving one cycle of latency.
module ula_74181
    import ula_74181_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       a_eq_b,
    output logic       c_out,
    output logic       p,
    output logic       g
);

    result_t w_coreRes;
    result_t r_res;

    ula_74181_core u_core (
        .i_a    (a),
        .i_b    (b),
        .i_s    (s),
        .i_m    (m),
        .i_c_in (c_in),
        .o_res  (w_coreRes)
    );

    // Output register: clears immediately on reset, otherwise loads the core result every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else begin
            r_res <= w_coreRes;
        end
    end

    assign f      = r_res.f;
    assign c_out  = r_res.c_out;
    assign p      = r_res.p;
    assign g      = r_res.g;
    assign a_eq_b = r_res.a_eq_b;

endmodule

// File: tb/tb_ula_74181.sv
// Directed testbench for ula_74181: hand-computed vectors, asynchronous
// reset behaviour, and a sweep against an independent behavioural model.
module tb_ula_74181;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [3:0] f;
    logic       a_eq_b;
    logic       c_out;
    logic       p;
    logic       g;

    int vectorCount;
    int missCount;

    ula_74181 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (f),
        .a_eq_b (a_eq_b),
        .c_out  (c_out),
        .p      (p),
        .g      (g)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference, packed as {f, c_out, p, g, a_eq_b}. Built from
    // integer arithmetic and a ripple-style look-ahead loop.
    function automatic logic [7:0] refModel(input logic mi, input logic [3:0] si,
                                            input logic [3:0] ai, input logic [3:0] bi,
                                            input logic ci);
        logic [3:0] rf;
        logic       rc;
        logic       rp;
        logic       rg;
        logic [3:0] xv;
        logic [3:0] yv;
        logic [3:0] qv;
        int         total;
        rf = 4'h0; rc = 1'b0; rp = 1'b0; rg = 1'b1;
        xv = 4'h0; yv = 4'h0; qv = 4'h0;
        if (mi) begin
            case (si)
                4'h0: rf = ~ai;         4'h1: rf = ~(ai | bi);
                4'h2: rf = ~ai & bi;    4'h3: rf = 4'h0;
                4'h4: rf = ~(ai & bi);  4'h5: rf = ~bi;
                4'h6: rf = ai ^ bi;     4'h7: rf = ai & ~bi;
                4'h8: rf = ai & bi;     4'h9: rf = ~(ai ^ bi);
                4'hA: rf = bi;          4'hB: rf = ~ai | bi;
                4'hC: rf = 4'hF;        4'hD: rf = ai | ~bi;
                4'hE: rf = ai | bi;     default: rf = ai;
            endcase
        end else begin
            case (si)
                4'h0: begin xv = ai;        yv = 4'hF;      end
                4'h1: begin xv = ai;        yv = ai | bi;   end
                4'h2: begin xv = ai | bi;   yv = 4'hF;      end
                4'h3: begin xv = 4'h0;      yv = 4'hF;      end
                4'h4: begin xv = ai;        yv = ai & bi;   end
                4'h5: begin xv = ai | bi;   yv = ai & bi;   end
                4'h6: begin xv = ai;        yv = ~bi;       end
                4'h7: begin xv = ai & ~bi;  yv = 4'hF;      end
                4'h8: begin xv = ai;        yv = ai & ~bi;  end
                4'h9: begin xv = ai;        yv = bi;        end
                4'hA: begin xv = ai | ~bi;  yv = ai & bi;   end
                4'hB: begin xv = ai & bi;   yv = 4'hF;      end
                4'hC: begin xv = ai;        yv = ai;        end
                4'hD: begin xv = ai | bi;   yv = ai;        end
                4'hE: begin xv = ai | ~bi;  yv = ai;        end
                default: begin xv = ai;     yv = 4'h0;      end
            endcase
            case (si)
                4'h0, 4'h3:       qv = 4'hF;
                4'h1, 4'h2, 4'h5,
                4'hD:             qv = ai | bi;
                4'h4, 4'hB:       qv = ai & bi;
                4'h6:             qv = ~bi;
                4'h7, 4'h8:       qv = ai & ~bi;
                4'h9:             qv = bi;
                4'hA, 4'hE:       qv = ai | ~bi;
                default:          qv = ai;
            endcase
            total = int'(xv) + int'(yv) + int'(ci);
            rf    = total[3:0];
            rc    = (total > 15);
            if (si == 4'h0 || si == 4'h2 || si == 4'h3 || si == 4'h6 ||
                si == 4'h7 || si == 4'hB)
                rc = ~rc;
            rp = 1'b1;
            rg = 1'b0;
            for (int i = 0; i < 4; i++) begin
                rg = (ai[i] & qv[i]) | ((ai[i] | qv[i]) & rg);
                rp = rp & (ai[i] | qv[i]);
            end
        end
        refModel = {rf, rc, rp, rg, (ai == bi)};
    endfunction

    // Drive one operand set away from the clock edge, then let it be registered.
    task automatic applyStimulus(input logic mi, input logic [3:0] si,
                                 input logic [3:0] ai, input logic [3:0] bi,
                                 input logic ci);
        @(negedge clk);
        m = mi; s = si; a = ai; b = bi; c_in = ci;
        @(posedge clk);
        #1;
    endtask

    // Compare the registered outputs against one expected bundle.
    task automatic checkOutput(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = {f, c_out, p, g, a_eq_b};
        vectorCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed f/c/p/g/eq=%b required=%b", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, hand-computed vectors, async reset mid-cycle, model sweep.
    initial begin
        logic [7:0] pairs [6];
        logic [7:0] pr;
        vectorCount = 0;
        missCount   = 0;
        pairs[0] = 8'h00; pairs[1] = 8'hF0; pairs[2] = 8'hA5;
        pairs[3] = 8'h33; pairs[4] = 8'h87; pairs[5] = 8'hFF;

        rst_n = 1'b0;
        m = 1'b0; s = 4'h9; a = 4'hA; b = 4'hA; c_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 8'b0000_0000);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_release_hold", 8'b0000_0000);

        applyStimulus(1'b0, 4'h9, 4'hA, 4'h5, 1'b0);
        checkOutput("add_a5", {4'b1111, 1'b0, 1'b1, 1'b0, 1'b0});
        applyStimulus(1'b0, 4'h9, 4'hF, 4'hF, 1'b1);
        checkOutput("add_ff_cin", {4'b1111, 1'b1, 1'b1, 1'b1, 1'b1});
        applyStimulus(1'b0, 4'h6, 4'h8, 4'h7, 1'b1);
        checkOutput("sub_8_7", {4'b0001, 1'b0, 1'b0, 1'b1, 1'b0});
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        checkOutput("dec_zero", {4'b1111, 1'b1, 1'b1, 1'b0, 1'b1});
        applyStimulus(1'b1, 4'h6, 4'hA, 4'h5, 1'b0);
        checkOutput("xor_cin0", {4'b1111, 1'b0, 1'b0, 1'b1, 1'b0});
        applyStimulus(1'b1, 4'h6, 4'hA, 4'h5, 1'b1);
        checkOutput("xor_cin1", {4'b1111, 1'b0, 1'b0, 1'b1, 1'b0});
        applyStimulus(1'b1, 4'h3, 4'h7, 4'h7, 1'b1);
        checkOutput("logic_zero", {4'b0000, 1'b0, 1'b0, 1'b1, 1'b1});
        applyStimulus(1'b1, 4'hC, 4'h2, 4'h9, 1'b0);
        checkOutput("logic_ones", {4'b1111, 1'b0, 1'b0, 1'b1, 1'b0});
        applyStimulus(1'b0, 4'hF, 4'hF, 4'h3, 1'b1);
        checkOutput("inc_wrap", {4'b0000, 1'b1, 1'b1, 1'b1, 1'b0});
        applyStimulus(1'b0, 4'hC, 4'h8, 4'h1, 1'b0);
        checkOutput("double_8", {4'b0000, 1'b1, 1'b0, 1'b1, 1'b0});

        // Asynchronous reset between edges, then recovery on the next edge.
        applyStimulus(1'b0, 4'h9, 4'hF, 4'hF, 1'b1);
        checkOutput("pre_async_reset", {4'b1111, 1'b1, 1'b1, 1'b1, 1'b1});
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_now", 8'b0000_0000);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("async_reset_hold", 8'b0000_0000);
        @(posedge clk);
        #1;
        checkOutput("after_reset_edge", {4'b1111, 1'b1, 1'b1, 1'b1, 1'b1});

        // Sweep both modes, all selects, both carry-ins, over a few operand pairs.
        for (int mi = 0; mi < 2; mi++) begin
            for (int si = 0; si < 16; si++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    for (int k = 0; k < 6; k++) begin
                        pr = pairs[k];
                        applyStimulus(mi[0], si[3:0], pr[7:4], pr[3:0], ci[0]);
                        checkOutput($sformatf("sweep_m%0d_s%0h_c%0d_ab%02h", mi, si, ci, pr),
                                    refModel(mi[0], si[3:0], pr[7:4], pr[3:0], ci[0]));
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
